// File: rtl/hazard_ctrl.sv
// Hazard detection and front-end control for the ID stage.
// Checks ID source registers against the EX/MEM/WB destinations.
// Optionally forwards from MEM/WB, freezes the front end after a branch,
// and counts stall cycles.
module hazard_ctrl #(
  parameter int unsigned REG_W          = 5,
  parameter int unsigned FWD_EN         = 1,
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_wreg,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_wreg,
  input  logic             dmem_wait,
  input  logic             imem_wait,
  input  logic             stall_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             bubble,
  output logic             pipe_en,
  output logic             imem_en,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, BR_WAIT} state_t;

  localparam logic [3:0] PEN_INIT = 4'(BRANCH_PENALTY - 1);

  state_t     state, state_nxt;
  logic [3:0] pen_cnt, pen_nxt;

  logic       ex_hit, mem_rs, mem_rt, wb_rs, wb_rt;
  logic       data_hazard;
  logic       waiting;
  logic [1:0] fwd_rs_c, fwd_rt_c;

  // A stage hits an operand only if it writes, the operand is read, and the
  // register is not r0.
  function automatic logic hit(input logic we, input logic [REG_W-1:0] wreg,
                               input logic [REG_W-1:0] src, input logic use_op);
    return we && use_op && (wreg == src) && (src != '0);
  endfunction

  // Operand match detection, hazard classification and forward selection.
  always_comb begin
    ex_hit  = hit(ex_regwrite, ex_wreg, id_rs, id_use_rs) ||
              hit(ex_regwrite, ex_wreg, id_rt, id_use_rt);
    mem_rs  = hit(mem_regwrite, mem_wreg, id_rs, id_use_rs);
    mem_rt  = hit(mem_regwrite, mem_wreg, id_rt, id_use_rt);
    wb_rs   = hit(wb_regwrite, wb_wreg, id_rs, id_use_rs);
    wb_rt   = hit(wb_regwrite, wb_wreg, id_rt, id_use_rt);
    waiting = dmem_wait || imem_wait;
    fwd_rs_c = 2'b00;
    fwd_rt_c = 2'b00;
    if (FWD_EN != 0) begin
      data_hazard = ex_hit;
      if (mem_rs)     fwd_rs_c = 2'b01;
      else if (wb_rs) fwd_rs_c = 2'b10;
      if (mem_rt)     fwd_rt_c = 2'b01;
      else if (wb_rt) fwd_rt_c = 2'b10;
    end else begin
      data_hazard = ex_hit || mem_rs || mem_rt || wb_rs || wb_rt;
    end
  end

  // Output decode and next state; reset, disable and memory waits override
  // the state machine in that order.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    bubble     = 1'b0;
    pipe_en    = 1'b0;
    imem_en    = 1'b0;
    fwd_rs     = 2'b00;
    fwd_rt     = 2'b00;
    state_nxt  = state;
    pen_nxt    = pen_cnt;
    if (rst) begin
      fwd_rs = fwd_rs_c;
      fwd_rt = fwd_rt_c;
      if (!enable) begin
        bubble = data_hazard;
      end else if (waiting) begin
        bubble  = data_hazard;
        imem_en = !dmem_wait;
      end else begin
        case (state)
          RUN: begin
            if (data_hazard) begin
              bubble  = 1'b1;
              pipe_en = 1'b1;
            end else if (id_branch) begin
              ifid_write = 1'b1;
              pipe_en    = 1'b1;
              state_nxt  = BR_WAIT;
              pen_nxt    = PEN_INIT;
            end else begin
              pc_write   = 1'b1;
              ifid_write = 1'b1;
              imem_en    = 1'b1;
              pipe_en    = 1'b1;
            end
          end
          BR_WAIT: begin
            bubble  = 1'b1;
            pipe_en = 1'b1;
            if (pen_cnt == 4'd0) begin
              pc_write  = 1'b1;
              imem_en   = 1'b1;
              state_nxt = RUN;
            end else begin
              pen_nxt = pen_cnt - 4'd1;
            end
          end
          default: state_nxt = RUN;
        endcase
      end
    end
  end

  // State and branch-penalty register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      pen_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pen_cnt <= pen_nxt;
    end
  end

  // Saturating stall-cycle counter; a clear beats an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall_clr) begin
      stall_cycles <= '0;
    end else if (enable && (bubble || waiting) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two instances (forwarding / legacy) driven with the
// same directed and random stimulus, compared against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned CNT_A = 5;
  localparam int unsigned CNT_B = 16;

  logic       clk = 1'b0;
  logic       rst, enable, id_use_rs, id_use_rt, id_branch;
  logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg, wb_wreg;
  logic       ex_regwrite, mem_regwrite, wb_regwrite;
  logic       dmem_wait, imem_wait, stall_clr;

  logic             a_pc_write, a_ifid_write, a_bubble, a_pipe_en, a_imem_en;
  logic [1:0]       a_fwd_rs, a_fwd_rt;
  logic [CNT_A-1:0] a_stall;
  logic             b_pc_write, b_ifid_write, b_bubble, b_pipe_en, b_imem_en;
  logic [1:0]       b_fwd_rs, b_fwd_rt;
  logic [CNT_B-1:0] b_stall;

  hazard_ctrl #(.REG_W(5), .FWD_EN(1), .BRANCH_PENALTY(3), .CNT_W(CNT_A)) u_fwd (
    .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
    .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .dmem_wait(dmem_wait), .imem_wait(imem_wait), .stall_clr(stall_clr),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .bubble(a_bubble),
    .pipe_en(a_pipe_en), .imem_en(a_imem_en), .fwd_rs(a_fwd_rs), .fwd_rt(a_fwd_rt),
    .stall_cycles(a_stall)
  );

  hazard_ctrl #(.REG_W(5), .FWD_EN(0), .BRANCH_PENALTY(1), .CNT_W(CNT_B)) u_leg (
    .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
    .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
    .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .dmem_wait(dmem_wait), .imem_wait(imem_wait), .stall_clr(stall_clr),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .bubble(b_bubble),
    .pipe_en(b_pipe_en), .imem_en(b_imem_en), .fwd_rs(b_fwd_rs), .fwd_rt(b_fwd_rt),
    .stall_cycles(b_stall)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Per-instance configuration and model state: remaining frozen cycles
  // after a branch (0 = running) and the ideal stall count.
  int              cfg_fwd [2] = '{1, 0};
  int              cfg_bp  [2] = '{3, 1};
  longint unsigned cfg_max [2] = '{31, 65535};
  int              br_left [2] = '{0, 0};
  longint unsigned cnt     [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic hit(input logic we, input logic [4:0] w,
                               input logic [4:0] s, input logic u);
    return we && u && (s != 5'd0) && (w == s);
  endfunction

  // Expected {pc_write, ifid_write, bubble, pipe_en, imem_en, fwd_rs, fwd_rt}
  // plus the model's next state.
  task automatic model(input int i, output logic [8:0] ev, output int nbr,
                       output longint unsigned ncnt);
    logic ex, mr, mt, wr, wt, hz, waiting;
    logic pc, iw, bb, pe, ie;
    logic [1:0] fr, ft;
    ex = hit(ex_regwrite, ex_wreg, id_rs, id_use_rs) || hit(ex_regwrite, ex_wreg, id_rt, id_use_rt);
    mr = hit(mem_regwrite, mem_wreg, id_rs, id_use_rs);
    mt = hit(mem_regwrite, mem_wreg, id_rt, id_use_rt);
    wr = hit(wb_regwrite, wb_wreg, id_rs, id_use_rs);
    wt = hit(wb_regwrite, wb_wreg, id_rt, id_use_rt);
    if (cfg_fwd[i] != 0) begin
      hz = ex;
      fr = mr ? 2'b01 : (wr ? 2'b10 : 2'b00);
      ft = mt ? 2'b01 : (wt ? 2'b10 : 2'b00);
    end else begin
      hz = ex || mr || mt || wr || wt;
      fr = 2'b00;
      ft = 2'b00;
    end
    waiting = dmem_wait || imem_wait;
    {pc, iw, bb, pe, ie} = 5'b0;
    nbr  = br_left[i];
    ncnt = cnt[i];
    if (!rst) begin
      fr = 2'b00; ft = 2'b00; nbr = 0; ncnt = 0;
    end else begin
      if (!enable) bb = hz;
      else if (waiting) begin
        bb = hz;
        ie = !dmem_wait;
      end else if (br_left[i] > 0) begin
        bb = 1'b1; pe = 1'b1;
        nbr = br_left[i] - 1;
        if (nbr == 0) begin pc = 1'b1; ie = 1'b1; end
      end else if (hz) begin
        bb = 1'b1; pe = 1'b1;
      end else if (id_branch) begin
        iw = 1'b1; pe = 1'b1;
        nbr = cfg_bp[i];
      end else begin
        {pc, iw, pe, ie} = 4'hF;
      end
      if (stall_clr) ncnt = 0;
      else if (enable && (bb || waiting) && cnt[i] < cfg_max[i]) ncnt = cnt[i] + 1;
    end
    ev = {pc, iw, bb, pe, ie, fr, ft};
  endtask

  // Inputs are set just after a rising edge; outputs are checked at the
  // falling edge, and the model advances with the next rising edge.
  task automatic step(input string tag);
    logic [8:0] ea, eb;
    int nb0, nb1;
    longint unsigned nc0, nc1;
    #4;
    if (!rst) begin
      br_left[0] = 0; br_left[1] = 0; cnt[0] = 0; cnt[1] = 0;
    end
    model(0, ea, nb0, nc0);
    model(1, eb, nb1, nc1);
    check({tag, "/fwd.out"}, 32'({a_pc_write, a_ifid_write, a_bubble, a_pipe_en, a_imem_en, a_fwd_rs, a_fwd_rt}), 32'(ea));
    check({tag, "/fwd.cnt"}, 32'(a_stall), 32'(cnt[0]));
    check({tag, "/leg.out"}, 32'({b_pc_write, b_ifid_write, b_bubble, b_pipe_en, b_imem_en, b_fwd_rs, b_fwd_rt}), 32'(eb));
    check({tag, "/leg.cnt"}, 32'(b_stall), 32'(cnt[1]));
    br_left[0] = nb0; br_left[1] = nb1;
    cnt[0] = nc0; cnt[1] = nc1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; enable = 1'b1;
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch = 1'b0;
    ex_regwrite = 1'b0; ex_wreg = '0;
    mem_regwrite = 1'b0; mem_wreg = '0;
    wb_regwrite = 1'b0; wb_wreg = '0;
    dmem_wait = 1'b0; imem_wait = 1'b0; stall_clr = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("reset0");
    step("reset1");
    idle();
    step("run");

    // EX match stalls; once it moves to MEM it is forwarded instead.
    id_rs = 5'd5; id_use_rs = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd5;
    step("ex_haz");
    ex_regwrite = 1'b0; mem_regwrite = 1'b1; mem_wreg = 5'd5;
    step("mem_fwd");

    // Register zero never matches.
    idle();
    id_rs = 5'd0; id_use_rs = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd0;
    step("r0");

    // MEM and WB both write r7: MEM wins.
    idle();
    id_rt = 5'd7; id_use_rt = 1'b1;
    mem_regwrite = 1'b1; mem_wreg = 5'd7; wb_regwrite = 1'b1; wb_wreg = 5'd7;
    step("memwb");

    // Branch penalty; extra branches during the penalty are ignored.
    idle();
    id_branch = 1'b1;
    for (int i = 0; i < 4; i++) step("branch");
    id_branch = 1'b0;
    for (int i = 0; i < 2; i++) step("br_after");

    // Data wait freezes the penalty.
    id_branch = 1'b1;
    step("br2");
    id_branch = 1'b0;
    step("br2_w");
    dmem_wait = 1'b1;
    for (int i = 0; i < 4; i++) step("br2_dwait");
    dmem_wait = 1'b0;
    for (int i = 0; i < 4; i++) step("br2_resume");

    // Instruction wait only keeps imem enabled.
    imem_wait = 1'b1;
    step("iwait");
    imem_wait = 1'b0;

    // Asynchronous reset in the middle of a penalty.
    id_branch = 1'b1;
    step("br3");
    id_branch = 1'b0;
    step("br3_w");
    rst = 1'b0;
    step("br3_rst");
    rst = 1'b1;
    for (int i = 0; i < 2; i++) step("br3_after");

    // Saturation of the small counter, then clear beats a bubble.
    idle();
    id_rs = 5'd9; id_use_rs = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd9;
    for (int i = 0; i < 37; i++) step("sat");
    stall_clr = 1'b1;
    step("clr");
    stall_clr = 1'b0;
    step("after_clr");

    // Disabled pipeline still reports the hazard as a bubble.
    enable = 1'b0;
    step("disabled");

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) != 0);
      enable       = ($urandom_range(0, 15) != 0);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_use_rs    = 1'($urandom);
      id_use_rt    = 1'($urandom);
      id_branch    = ($urandom_range(0, 7) == 0);
      ex_regwrite  = 1'($urandom);
      ex_wreg      = 5'($urandom_range(0, 7));
      mem_regwrite = 1'($urandom);
      mem_wreg     = 5'($urandom_range(0, 7));
      wb_regwrite  = 1'($urandom);
      wb_wreg      = 5'($urandom_range(0, 7));
      dmem_wait    = ($urandom_range(0, 15) == 0);
      imem_wait    = ($urandom_range(0, 15) == 0);
      stall_clr    = ($urandom_range(0, 63) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
